// File: rtl/rgb_gray_fb_writer_if.sv
// rgb_gray_fb_writer_if
//   Bundles the pixel-write, frame-control and read-port signals of the
//   frame-buffer writer.
//   master: pixel source / frame consumer (drives pixel_we, pixel_addr,
//           rgb_data, frame_done, rd_en, rd_addr).
//   slave : rgb_gray_fb_writer (drives rd_data, rd_valid, frame_ready,
//           rd_bank, frame_cnt, err_addr, err_overrun).
interface rgb_gray_fb_writer_if #(
    parameter int ADDR_W = 16
);
    logic              pixel_we;
    logic [ADDR_W-1:0] pixel_addr;
    logic [23:0]       rgb_data;
    logic              frame_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              frame_ready;
    logic              rd_bank;
    logic [7:0]        frame_cnt;
    logic              err_addr;
    logic              err_overrun;

    modport master (
        output pixel_we, pixel_addr, rgb_data, frame_done, rd_en, rd_addr,
        input  rd_data, rd_valid, frame_ready, rd_bank, frame_cnt,
               err_addr, err_overrun
    );

    modport slave (
        input  pixel_we, pixel_addr, rgb_data, frame_done, rd_en, rd_addr,
        output rd_data, rd_valid, frame_ready, rd_bank, frame_cnt,
               err_addr, err_overrun
    );
endinterface

// File: rtl/rgb_gray_fb_writer.sv
// rgb_gray_fb_writer
//   Converts RGB888 pixels to 8-bit luminance Y = (77R + 150G + 29B) >> 8 in a
//   two-stage pipeline and writes them into the write bank of a double-buffered
//   IMG_W x IMG_H frame buffer. frame_done drains the pipeline and swaps banks;
//   the completed frame is read back through a 1-cycle-latency read port.
//
//   Optional build macro: GRAY_ROUND_EN -- round-to-nearest (+128 before the
//   shift, clamped to 0xFF) instead of truncation. Latency is unchanged.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     bus (slave)       pixel_we/pixel_addr/rgb_data/frame_done in,
//                       rd_en/rd_addr in, rd_data/rd_valid out,
//                       frame_ready, rd_bank, frame_cnt, err_addr,
//                       err_overrun status out
module rgb_gray_fb_writer #(
    parameter int IMG_W  = 176,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    rgb_gray_fb_writer_if.slave bus
);
    localparam int              PIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W + 1)'(PIX);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] SWAP  = 2'd2;

    logic [1:0]        state;
    logic              rd_bank_r;
    logic [7:0]        frame_cnt_r;
    logic              err_addr_r;
    logic              err_overrun_r;
    logic [7:0]        rd_data_r;
    logic              rd_valid_r;

    logic [15:0]       prod_r_p1;
    logic [15:0]       prod_g_p1;
    logic [15:0]       prod_b_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              vld_p1;

    logic [7:0]        y_p2;
    logic [ADDR_W-1:0] addr_p2;
    logic              vld_p2;

    // Bank is the outer index so the bank bit selects the buffer directly.
    logic [7:0]        mem [2][PIX];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              accept;

    function automatic logic [7:0] gray_of(input logic [15:0] pr,
                                           input logic [15:0] pg,
                                           input logic [15:0] pb);
`ifdef GRAY_ROUND_EN
        logic [16:0] s;
        s = {1'b0, pr} + {1'b0, pg} + {1'b0, pb} + 17'd128;
        return s[16] ? 8'hFF : s[15:8];
`else
        logic [15:0] s;
        s = pr + pg + pb;
        return s[15:8];
`endif
    endfunction

    assign wr_in_range = ({1'b0, bus.pixel_addr} < PIX_LIM);
    assign rd_in_range = ({1'b0, bus.rd_addr} < PIX_LIM);
    assign accept      = bus.pixel_we && (state == FILL) && wr_in_range;

    // Control: FSM, valids, bank pointer, counters, sticky errors
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FILL;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            rd_bank_r     <= 1'b1;
            frame_cnt_r   <= 8'd0;
            err_addr_r    <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;

            if (bus.pixel_we && !wr_in_range)
                err_addr_r <= 1'b1;
            if (bus.pixel_we && (state != FILL))
                err_overrun_r <= 1'b1;

            case (state)
                FILL: begin
                    if (bus.frame_done)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Nothing enters S1 while draining, so an empty S1 means
                    // S2 is empty after this edge as well.
                    if (!vld_p1)
                        state <= SWAP;
                end
                SWAP: begin
                    rd_bank_r   <= ~rd_bank_r;
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                    state       <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

    // Stage 1: channel products
    always_ff @(posedge clk) begin
        prod_r_p1 <= 16'(bus.rgb_data[23:16]) * 16'd77;
        prod_g_p1 <= 16'(bus.rgb_data[15:8])  * 16'd150;
        prod_b_p1 <= 16'(bus.rgb_data[7:0])   * 16'd29;
        addr_p1   <= bus.pixel_addr;
    end

    // Stage 2: luminance
    always_ff @(posedge clk) begin
        y_p2    <= gray_of(prod_r_p1, prod_g_p1, prod_b_p1);
        addr_p2 <= addr_p1;
    end

    // Frame-buffer write into the bank not exposed to the reader
    always_ff @(posedge clk) begin
        if (vld_p2)
            mem[~rd_bank_r][addr_p2] <= y_p2;
    end

    // Read port: bank sampled in the rd_en cycle, so a same-cycle swap does
    // not affect this read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en)
                rd_data_r <= rd_in_range ? mem[rd_bank_r][bus.rd_addr] : 8'h00;
        end
    end

    assign bus.rd_data     = rd_data_r;
    assign bus.rd_valid    = rd_valid_r;
    assign bus.frame_ready = (state == SWAP);
    assign bus.rd_bank     = rd_bank_r;
    assign bus.frame_cnt   = frame_cnt_r;
    assign bus.err_addr    = err_addr_r;
    assign bus.err_overrun = err_overrun_r;
endmodule

// File: tb/tb_rgb_gray_fb_writer.sv
// tb_rgb_gray_fb_writer
//   Random-stimulus bench for rgb_gray_fb_writer. A reference model keeps two
//   frame images, the exposed bank, frame count and error flags, and predicts
//   swap timing from the frame_done / last-pixel relationship.
module tb_rgb_gray_fb_writer;
    localparam int IMG_W  = 176;
    localparam int IMG_H  = 240;
    localparam int ADDR_W = 16;
    localparam int PIX    = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rgb_gray_fb_writer_if #(.ADDR_W(ADDR_W)) bus ();

    rgb_gray_fb_writer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          fd_at = -10;
    int          swap_at = -10;
    int          fr_count = 0;
    int          fr_last  = -1;
    logic [7:0]  img [2][PIX];
    int          m_bank;
    int          m_cnt;
    bit          m_eaddr;
    bit          m_eovr;
    logic [7:0]  m_rd;

    function automatic int luma(input logic [23:0] c);
        int s;
        s = 77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0]);
`ifdef GRAY_ROUND_EN
        s = (s + 128) / 256;
        if (s > 255) s = 255;
        return s;
`else
        return s / 256;
`endif
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One clock cycle of stimulus with model update and read-data check.
    task automatic cycle(input bit we, input int pa, input logic [23:0] rgb,
                         input bit fd, input bit re, input int ra);
        bit busy;
        bit acc;
        if (bus.frame_ready === 1'b1) begin
            fr_count++;
            fr_last = cyc;
        end
        busy = (cyc > fd_at) && (cyc <= swap_at);
        bus.pixel_we   = we;
        bus.pixel_addr = 16'(pa);
        bus.rgb_data   = rgb;
        bus.frame_done = fd;
        bus.rd_en      = re;
        bus.rd_addr    = 16'(ra);
        if (re) m_rd = (ra < PIX) ? img[m_bank][ra] : 8'h00;
        acc = we && !busy && (pa < PIX);
        if (we && pa >= PIX) m_eaddr = 1'b1;
        if (we && busy) m_eovr = 1'b1;
        if (acc) img[1 - m_bank][pa] = 8'(luma(rgb));
        if (fd && !busy) begin
            fd_at   = cyc;
            swap_at = cyc + (acc ? 3 : 2);
        end
        if (cyc == swap_at) begin
            m_bank = 1 - m_bank;
            m_cnt  = (m_cnt + 1) % 256;
        end
        tick();
        if (re) begin
            chk_eq("rd_valid", 32'(bus.rd_valid), 32'd1);
            chk_eq($sformatf("rd_data[%0d]", ra), 32'(bus.rd_data), 32'(m_rd));
        end else if (cyc % 32 == 0) begin
            chk_eq("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 24'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.pixel_we = 1'b0; bus.frame_done = 1'b0; bus.rd_en = 1'b0;
        m_bank = 1; m_cnt = 0; m_eaddr = 1'b0; m_eovr = 1'b0;
        fd_at = -10; swap_at = -10; m_rd = 8'h00;
    endtask

    task automatic chk_status(input string tag);
        chk_eq({tag, ".rd_bank"},     32'(bus.rd_bank),     32'(m_bank));
        chk_eq({tag, ".frame_cnt"},   32'(bus.frame_cnt),   32'(m_cnt));
        chk_eq({tag, ".err_addr"},    32'(bus.err_addr),    32'(m_eaddr));
        chk_eq({tag, ".err_overrun"}, 32'(bus.err_overrun), 32'(m_eovr));
    endtask

    initial begin
        logic [23:0] cols [4];
        logic [7:0]  lit  [4];
        logic [23:0] rgb;
        int          ra;
        int          frs;

        cols[0] = 24'hFFFFFF; cols[1] = 24'hFF0000; cols[2] = 24'h00FF00; cols[3] = 24'h0000FF;
`ifdef GRAY_ROUND_EN
        lit[0] = 8'hFF; lit[1] = 8'h4D; lit[2] = 8'h95; lit[3] = 8'h1D;
`else
        lit[0] = 8'hFF; lit[1] = 8'h4C; lit[2] = 8'h95; lit[3] = 8'h1C;
`endif
        bus.pixel_we = 1'b0; bus.pixel_addr = '0; bus.rgb_data = '0;
        bus.frame_done = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
        reset = 1'b1;
        tick();
        do_reset();

        // Reset state
        chk_eq("rst.rd_valid",    32'(bus.rd_valid),    32'd0);
        chk_eq("rst.rd_data",     32'(bus.rd_data),     32'd0);
        chk_eq("rst.frame_ready", 32'(bus.frame_ready), 32'd0);
        chk_status("rst");

        // Four primary pixels, frame_done with the last one
        for (int i = 0; i < 4; i++) cycle(1, i, cols[i], i == 3, 0, 0);
        idle(6);
        chk_eq("f1.fr_count", 32'(fr_count), 32'd1);
        chk_eq("f1.latency",  32'(fr_last - fd_at), 32'd3);
        chk_eq("f1.rd_bank_abs", 32'(bus.rd_bank), 32'd0);
        chk_status("f1");
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 24'h0, 0, 1, i);
            chk_eq($sformatf("f1.lit[%0d]", i), 32'(bus.rd_data), 32'(lit[i]));
        end
        cycle(0, 0, 24'h0, 0, 1, PIX);
        chk_eq("f1.oob_read", 32'(bus.rd_data), 32'd0);

        // Full frame of random pixels, back to back
        for (int a = 0; a < PIX; a++) begin
            rgb = 24'($urandom);
            cycle(1, a, rgb, a == PIX - 1, 0, 0);
        end
        idle(6);
        chk_eq("f2.fr_count", 32'(fr_count), 32'd2);
        chk_eq("f2.latency",  32'(fr_last - fd_at), 32'd3);
        chk_status("f2");
        cycle(0, 0, 24'h0, 0, 1, 0);
        cycle(0, 0, 24'h0, 0, 1, PIX - 1);
        for (int i = 0; i < 200; i++) cycle(0, 0, 24'h0, 0, 1, int'($urandom_range(PIX - 1, 0)));

        // All-black frame written while frame 2 is being read; reads continue
        // through the swap cycle and beyond.
        for (int a = 0; a < PIX; a++) begin
            ra = int'($urandom_range(PIX - 1, 0));
            cycle(1, a, 24'h0, a == PIX - 1, (a < 300) || (a >= PIX - 10), ra);
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 24'h0, 0, 1, int'($urandom_range(PIX - 1, 0)));
        chk_eq("f3.fr_count", 32'(fr_count), 32'd3);
        chk_eq("f3.latency",  32'(fr_last - fd_at), 32'd3);
        chk_status("f3");
        for (int i = 0; i < 100; i++) cycle(0, 0, 24'h0, 0, 1, int'($urandom_range(PIX - 1, 0)));

        // Short frame with errors: bad address, empty-pipeline frame_done,
        // pixel one cycle after frame_done
        for (int a = 10; a < 13; a++) cycle(1, a, 24'($urandom), 0, 0, 0);
        cycle(1, PIX, 24'h123456, 0, 0, 0);
        idle(2);
        cycle(0, 0, 24'h0, 1, 0, 0);
        cycle(1, 13, 24'hFFFFFF, 0, 0, 0);
        idle(5);
        chk_eq("f4.fr_count", 32'(fr_count), 32'd4);
        chk_eq("f4.latency",  32'(fr_last - fd_at), 32'd2);
        chk_eq("f4.err_addr_abs",    32'(bus.err_addr),    32'd1);
        chk_eq("f4.err_overrun_abs", 32'(bus.err_overrun), 32'd1);
        chk_status("f4");
        for (int a = 10; a < 14; a++) cycle(0, 0, 24'h0, 0, 1, a);
        idle(20);
        chk_status("f4.sticky");

        // Reset in the middle of a frame
        do_reset();
        chk_status("r2");
        for (int a = 0; a < 1000; a++) cycle(1, a, 24'($urandom), 0, 0, 0);
        bus.pixel_we = 1'b1; bus.pixel_addr = 16'd1000; bus.frame_done = 1'b1;
        frs = fr_count;
        do_reset();
        idle(8);
        chk_eq("mid.no_ready", 32'(fr_count), 32'(frs));
        chk_eq("mid.frame_cnt_abs", 32'(bus.frame_cnt), 32'd0);
        chk_eq("mid.rd_bank_abs",   32'(bus.rd_bank),   32'd1);
        chk_status("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
